// File: rtl/pong_pkg.sv
// Shared constants, colour codes and state encodings for the Pong game controller.
package pong_pkg;

  localparam logic [9:0] MAX_X       = 10'd640;
  localparam logic [9:0] MAX_Y       = 10'd480;
  localparam logic [9:0] WALL_X_L    = 10'd32;
  localparam logic [9:0] WALL_X_R    = 10'd35;
  localparam logic [9:0] BAR_X_L     = 10'd600;
  localparam logic [9:0] BAR_X_R     = 10'd603;
  localparam logic [9:0] BAR_H       = 10'd73;
  localparam logic [9:0] BAR_V       = 10'd4;
  localparam logic [9:0] BAR_Y_RST   = 10'd204;
  localparam logic [9:0] BALL_SIZE   = 10'd8;
  localparam logic [9:0] BALL_V      = 10'd2;
  localparam logic [9:0] BALL_V_MAX  = 10'd4;
  localparam logic [9:0] SERVE_X     = 10'd580;
  localparam logic [9:0] SERVE_Y     = 10'd238;
  localparam logic [1:0] LIVES       = 2'd3;
  localparam logic [5:0] MISS_FRAMES = 6'd60;

  // Offsets from an object's origin to its far edge (inclusive).
  localparam logic [9:0] BALL_OFS  = BALL_SIZE - 10'd1;
  localparam logic [9:0] BAR_OFS   = BAR_H - 10'd1;
  localparam logic [9:0] BAR_Y_MAX = MAX_Y - BAR_H;

  localparam logic [11:0] WALL_RGB = 12'hF00;
  localparam logic [11:0] BAR_RGB  = 12'h00F;
  localparam logic [11:0] BALL_RGB = 12'h0F0;

  typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, MISS = 2'd2, OVER = 2'd3} game_state_t;
  typedef enum logic {DIR_LEFT = 1'b0, DIR_RIGHT = 1'b1} x_dir_t;
  typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} y_dir_t;

endpackage

// File: rtl/pong_paddle_ctrl.sv
// Paddle position: steps bar_y_t once per frame from the buttons, clamped to the screen.
module pong_paddle_ctrl
  import pong_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       enable,
  input  logic       btn_up,
  input  logic       btn_down,
  output logic [9:0] bar_y_t
);

  // NOTE: compare before stepping so the 10-bit position never wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      bar_y_t <= BAR_Y_RST;
    end else if (frame_tick && enable) begin
      if (btn_up && !btn_down)
        bar_y_t <= (bar_y_t >= BAR_V) ? bar_y_t - BAR_V : 10'd0;
      else if (btn_down && !btn_up)
        bar_y_t <= (bar_y_t >= BAR_Y_MAX - BAR_V) ? BAR_Y_MAX : bar_y_t + BAR_V;
    end
  end

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: ball motion, collisions, hits/lives and the serve/miss/over FSM.
// Optional build macro PONG_SPEEDUP_EN raises the ball step every 4th paddle hit.
module pong_game_ctrl
  import pong_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_serve,
  output logic [9:0] bar_y_t,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic [7:0] hit_cnt,
  output logic [1:0] lives,
  output logic [1:0] state,
  output logic       hit_pulse
);

  game_state_t st;
  x_dir_t      x_dir, nx_x_dir;
  y_dir_t      y_dir, nx_y_dir;
  logic [5:0]  miss_cnt;
  logic [9:0]  step;
  logic [9:0]  ball_r, ball_b, nx_ball_x, nx_ball_y;
  logic        miss, hit;

  assign state = st;

  pong_paddle_ctrl u_paddle (
    .clk        (clk),
    .rst        (rst),
    .frame_tick (frame_tick),
    .enable     (st == IDLE || st == PLAY),
    .btn_up     (btn_up),
    .btn_down   (btn_down),
    .bar_y_t    (bar_y_t)
  );

  assign ball_r = ball_x + BALL_OFS;
  assign ball_b = ball_y + BALL_OFS;
  assign miss   = ball_r > MAX_X - 10'd1;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    nx_y_dir = y_dir;
    nx_x_dir = x_dir;
    hit      = 1'b0;
    if (ball_y <= step)
      nx_y_dir = DIR_DOWN;
    else if (ball_b >= MAX_Y - 10'd1 - step)
      nx_y_dir = DIR_UP;
    if (ball_x <= WALL_X_R + 10'd1) begin
      nx_x_dir = DIR_RIGHT;
    end else if (x_dir == DIR_RIGHT && ball_r >= BAR_X_L && ball_r <= BAR_X_R &&
                 ball_y <= bar_y_t + BAR_OFS && ball_b >= bar_y_t) begin
      nx_x_dir = DIR_LEFT;
      hit      = 1'b1;
    end
    // Move with this tick's directions so a bounce takes effect immediately.
    nx_ball_x = (nx_x_dir == DIR_RIGHT) ? ball_x + step : ball_x - step;
    nx_ball_y = (nx_y_dir == DIR_DOWN)  ? ball_y + step : ball_y - step;
  end

`ifdef PONG_SPEEDUP_EN
  always_ff @(posedge clk) begin
    if (rst || st == IDLE)
      step <= BALL_V;
    else if (st == PLAY && frame_tick && !miss && hit &&
             hit_cnt[1:0] == 2'b11 && hit_cnt != 8'hFF && step < BALL_V_MAX)
      step <= step + 10'd1;
  end
`else
  assign step = BALL_V;
`endif

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      st        <= IDLE;
      ball_x    <= SERVE_X;
      ball_y    <= SERVE_Y;
      x_dir     <= DIR_LEFT;
      y_dir     <= DIR_DOWN;
      hit_cnt   <= 8'd0;
      lives     <= LIVES;
      hit_pulse <= 1'b0;
      miss_cnt  <= 6'd0;
    end else begin
      hit_pulse <= 1'b0;
      case (st)
        IDLE: begin
          ball_x <= SERVE_X;
          ball_y <= SERVE_Y;
          if (btn_serve) begin
            st    <= PLAY;
            x_dir <= DIR_LEFT;
            y_dir <= DIR_DOWN;
          end
        end
        PLAY: if (frame_tick) begin
          if (miss) begin
            st       <= MISS;
            miss_cnt <= 6'd0;
            if (lives != 2'd0) lives <= lives - 2'd1;
          end else begin
            x_dir  <= nx_x_dir;
            y_dir  <= nx_y_dir;
            ball_x <= nx_ball_x;
            ball_y <= nx_ball_y;
            if (hit) begin
              hit_pulse <= 1'b1;
              if (hit_cnt != 8'hFF) hit_cnt <= hit_cnt + 8'd1;
            end
          end
        end
        MISS: if (frame_tick) begin
          if (miss_cnt == MISS_FRAMES - 6'd1) begin
            miss_cnt <= 6'd0;
            if (lives == 2'd0) begin
              st <= OVER;
            end else begin
              st     <= IDLE;
              ball_x <= SERVE_X;
              ball_y <= SERVE_Y;
            end
          end else begin
            miss_cnt <= miss_cnt + 6'd1;
          end
        end
        OVER: if (btn_serve) begin
          st      <= IDLE;
          lives   <= LIVES;
          hit_cnt <= 8'd0;
          ball_x  <= SERVE_X;
          ball_y  <= SERVE_Y;
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed bench for pong_game_ctrl: reset, paddle clamps, bounces, paddle hit, miss/over sequence.
module tb_pong_game_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       frame_tick = 1'b0;
  logic       btn_up = 1'b0;
  logic       btn_down = 1'b0;
  logic       btn_serve = 1'b0;
  logic [9:0] bar_y_t, ball_x, ball_y;
  logic [7:0] hit_cnt;
  logic [1:0] lives, state;
  logic       hit_pulse;

  int checks = 0;
  int failures = 0;

  pong_game_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .frame_tick (frame_tick),
    .btn_up     (btn_up),
    .btn_down   (btn_down),
    .btn_serve  (btn_serve),
    .bar_y_t    (bar_y_t),
    .ball_x     (ball_x),
    .ball_y     (ball_y),
    .hit_cnt    (hit_cnt),
    .lives      (lives),
    .state      (state),
    .hit_pulse  (hit_pulse)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One frame_tick pulse; returns at the falling edge after the tick edge.
  task automatic tick();
    @(negedge clk) frame_tick = 1'b1;
    @(negedge clk) frame_tick = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic serve();
    @(negedge clk) btn_serve = 1'b1;
    @(negedge clk) btn_serve = 1'b0;
  endtask

  // Serve with paddle at 0 (never in the ball's path), let the ball miss, then sit out MISS.
  task automatic miss_round(input int exp_lives, input int exp_end, input int exp_end_x);
    serve();
    check("round_serve_state", state, 1);
    ticks(571);
    check("round_pre_miss_x", ball_x, 634);
    check("round_pre_miss_state", state, 1);
    tick();
    check("round_miss_state", state, 2);
    check("round_miss_lives", lives, exp_lives);
    ticks(59);
    check("round_miss_hold", state, 2);
    tick();
    check("round_end_state", state, exp_end);
    check("round_end_x", ball_x, exp_end_x);
  endtask

  initial begin
    repeat (10) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    check("rst_bar", bar_y_t, 204);
    check("rst_ball_x", ball_x, 580);
    check("rst_ball_y", ball_y, 238);
    check("rst_state", state, 0);
    check("rst_lives", lives, 3);
    check("rst_hits", hit_cnt, 0);
    check("rst_pulse", hit_pulse, 0);

    btn_up = 1'b1;
    ticks(50);
    check("bar_up_50", bar_y_t, 4);
    ticks(10);
    check("bar_up_clamp", bar_y_t, 0);
    btn_up = 1'b0;
    btn_down = 1'b1;
    ticks(101);
    check("bar_down_101", bar_y_t, 404);
    ticks(49);
    check("bar_down_clamp", bar_y_t, 407);
    btn_down = 1'b0;
    btn_up = 1'b1;
    btn_down = 1'b1;
    ticks(3);
    check("bar_both_hold", bar_y_t, 407);
    btn_up = 1'b0;
    btn_down = 1'b0;
    check("idle_parked_x", ball_x, 580);

    // PLAY tick counts n below are frame_ticks since the serve.
    serve();
    check("serve_state", state, 1);
    ticks(5);
    check("play5_x", ball_x, 570);
    check("play5_y", ball_y, 248);
    ticks(111);
    check("n116_bottom_y", ball_y, 470);
    tick();
    check("n117_bounce_up_y", ball_y, 468);
    ticks(155);
    check("n272_wall_x", ball_x, 36);
    tick();
    check("n273_wall_bounce_x", ball_x, 38);
    ticks(77);
    check("n350_top_y", ball_y, 2);
    tick();
    check("n351_bounce_down_y", ball_y, 4);
    ticks(200);
    check("n551_x", ball_x, 594);
    check("n551_y", ball_y, 404);
    check("n551_hits", hit_cnt, 0);
    tick();
    check("hit_pulse_on", hit_pulse, 1);
    check("hit_cnt_1", hit_cnt, 1);
    check("hit_back_x", ball_x, 592);
    check("hit_y", ball_y, 406);
    @(negedge clk);
    check("hit_pulse_off", hit_pulse, 0);

    // Paddle leaves; ball returns at y=356 and misses.
    btn_up = 1'b1;
    ticks(577);
    check("n1129_x", ball_x, 634);
    check("n1129_state", state, 1);
    check("n1129_bar", bar_y_t, 0);
    check("n1129_hits", hit_cnt, 1);
    tick();
    check("miss1_state", state, 2);
    check("miss1_lives", lives, 2);
    check("miss1_frozen_x", ball_x, 634);
    btn_up = 1'b0;
    btn_down = 1'b1;
    ticks(59);
    check("miss1_hold", state, 2);
    check("miss_bar_frozen", bar_y_t, 0);
    tick();
    btn_down = 1'b0;
    check("miss1_idle", state, 0);
    check("miss1_park_x", ball_x, 580);
    check("miss1_park_y", ball_y, 238);
    check("miss1_bar", bar_y_t, 0);

    miss_round(1, 0, 580);
    miss_round(0, 3, 634);
    check("over_hits", hit_cnt, 1);
    btn_down = 1'b1;
    ticks(2);
    btn_down = 1'b0;
    check("over_ball_frozen", ball_x, 634);
    check("over_bar_frozen", bar_y_t, 0);
    check("over_state", state, 3);
    serve();
    check("restart_state", state, 0);
    check("restart_lives", lives, 3);
    check("restart_hits", hit_cnt, 0);
    check("restart_x", ball_x, 580);
    check("restart_y", ball_y, 238);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
